// File: rtl/ft_recovery_ctrl_if.sv
// Signal bundle between the lockstep recovery controller and its surroundings:
// comparator flags, core halt/resume controls, shadow-file read port and register-file write port.
interface ft_recovery_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
);
  logic                  error_i;
  logic                  valid_instr_i;
  logic [DATA_WIDTH-1:0] fault_pc_i;
  logic                  halt_o;
  logic                  halt_ack_i;
  logic [ADDR_WIDTH-1:0] sh_raddr_o;
  logic [DATA_WIDTH-1:0] sh_rdata_i;
  logic                  rf_we_o;
  logic [ADDR_WIDTH-1:0] rf_waddr_o;
  logic [DATA_WIDTH-1:0] rf_wdata_o;
  logic                  resume_o;
  logic [DATA_WIDTH-1:0] resume_pc_o;
  logic                  busy_o;
  logic [CNT_WIDTH-1:0]  recovery_cnt_o;

  // Controller side
  modport slave (
    input  error_i, valid_instr_i, fault_pc_i, halt_ack_i, sh_rdata_i,
    output halt_o, sh_raddr_o, rf_we_o, rf_waddr_o, rf_wdata_o,
    output resume_o, resume_pc_o, busy_o, recovery_cnt_o
  );

  // Comparator / core / shadow-file side
  modport master (
    output error_i, valid_instr_i, fault_pc_i, halt_ack_i, sh_rdata_i,
    input  halt_o, sh_raddr_o, rf_we_o, rf_waddr_o, rf_wdata_o,
    input  resume_o, resume_pc_o, busy_o, recovery_cnt_o
  );
endinterface

// File: rtl/ft_recovery_ctrl.sv
// Lockstep recovery controller: on a qualified mismatch it halts both cores, rewrites
// registers 1..NUM_REGS-1 from the shadow file, then restarts both cores at the faulting PC.
module ft_recovery_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  ft_recovery_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HALT    = 2'd1,
    RESTORE = 2'd2,
    RESUME  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] pc_reg;
  logic [DATA_WIDTH-1:0] resume_pc_reg;
  logic                  halt_reg;
  logic                  we_reg;
  logic                  resume_reg;
  logic                  busy_reg;
  logic [CNT_WIDTH-1:0]  cnt_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      pc_reg        <= '0;
      resume_pc_reg <= '0;
      halt_reg      <= 1'b0;
      we_reg        <= 1'b0;
      resume_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Comparator output is only trusted while the cores are running.
          if (bus.error_i && bus.valid_instr_i) begin
            pc_reg    <= bus.fault_pc_i;
            state_reg <= HALT;
            halt_reg  <= 1'b1;
            busy_reg  <= 1'b1;
          end
        end
        HALT: begin
          if (bus.halt_ack_i) begin
            state_reg <= RESTORE;
            addr_reg  <= ADDR_WIDTH'(1);  // x0 is hardwired, skip it
            we_reg    <= 1'b1;
          end
        end
        RESTORE: begin
          if (addr_reg == LAST_ADDR) begin
            state_reg     <= RESUME;
            addr_reg      <= '0;
            we_reg        <= 1'b0;
            halt_reg      <= 1'b0;
            resume_reg    <= 1'b1;
            resume_pc_reg <= pc_reg;
            if (cnt_reg != CNT_MAX) begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            addr_reg <= addr_reg + 1'b1;
          end
        end
        RESUME: begin
          state_reg  <= IDLE;
          resume_reg <= 1'b0;
          busy_reg   <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Shadow data flows straight through so each register is restored in a single cycle.
  assign bus.sh_raddr_o     = addr_reg;
  assign bus.rf_waddr_o     = addr_reg;
  assign bus.rf_we_o        = we_reg;
  assign bus.rf_wdata_o     = we_reg ? bus.sh_rdata_i : '0;
  assign bus.halt_o         = halt_reg;
  assign bus.resume_o       = resume_reg;
  assign bus.resume_pc_o    = resume_pc_reg;
  assign bus.busy_o         = busy_reg;
  assign bus.recovery_cnt_o = cnt_reg;

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Randomized bench for ft_recovery_ctrl: a shadow-file array feeds the controller and a
// transaction-level model predicts the write sequence, resume PC, latency and event count.
module tb_ft_recovery_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int CW = 8;
  localparam int CNT_SAT = (1 << CW) - 1;

  logic clk_i;
  logic rst_ni;

  ft_recovery_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  ft_recovery_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_REGS  (NR),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  logic [DW-1:0] shadow_mem [NR];
  assign bus.sh_rdata_i = shadow_mem[bus.sh_raddr_o];

  int tests_run = 0;
  int failures  = 0;
  int model_cnt = 0;
  int rec_idx   = 0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string ctx);
    check({ctx, ".halt"},      64'(bus.halt_o),         64'(0));
    check({ctx, ".we"},        64'(bus.rf_we_o),        64'(0));
    check({ctx, ".waddr"},     64'(bus.rf_waddr_o),     64'(0));
    check({ctx, ".wdata"},     64'(bus.rf_wdata_o),     64'(0));
    check({ctx, ".raddr"},     64'(bus.sh_raddr_o),     64'(0));
    check({ctx, ".resume"},    64'(bus.resume_o),       64'(0));
    check({ctx, ".resume_pc"}, 64'(bus.resume_pc_o),    64'(0));
    check({ctx, ".busy"},      64'(bus.busy_o),         64'(0));
    check({ctx, ".cnt"},       64'(bus.recovery_cnt_o), 64'(0));
  endtask

  // One full recovery transaction. abort_at>0 applies reset when that write is on the bus.
  task automatic do_recovery(input logic [DW-1:0] pc, input int ack_dly,
                             input bit fixed_fill, input bit noise, input int abort_at);
    int  k;
    int  writes;
    int  exp_addr;
    bit  done;
    for (int i = 0; i < NR; i++) begin
      shadow_mem[i] = fixed_fill ? (32'hA5A5_0000 + 32'(i)) : $urandom;
    end

    @(negedge clk_i);
    bus.error_i       = 1'b1;
    bus.valid_instr_i = 1'b1;
    bus.fault_pc_i    = pc;
    bus.halt_ack_i    = 1'b0;

    @(negedge clk_i);
    k = 1;
    bus.error_i       = noise;
    bus.valid_instr_i = noise;
    bus.fault_pc_i    = $urandom;
    check("halt_rise", 64'(bus.halt_o), 64'(1));
    check("busy_rise", 64'(bus.busy_o), 64'(1));
    check("we_in_halt", 64'(bus.rf_we_o), 64'(0));

    for (int d = 0; d < ack_dly; d++) begin
      @(negedge clk_i);
      k++;
      check("halt_hold", 64'(bus.halt_o), 64'(1));
      check("we_wait_ack", 64'(bus.rf_we_o), 64'(0));
    end
    bus.halt_ack_i = 1'b1;

    writes   = 0;
    exp_addr = 1;
    done     = 1'b0;
    while (!done && k < 200) begin
      @(negedge clk_i);
      k++;
      if (noise) begin
        bus.error_i       = 1'b1;
        bus.valid_instr_i = 1'b1;
      end
      if (bus.rf_we_o) begin
        check("waddr", 64'(bus.rf_waddr_o), 64'(exp_addr));
        check("raddr", 64'(bus.sh_raddr_o), 64'(exp_addr));
        check("wdata", 64'(bus.rf_wdata_o), 64'(shadow_mem[exp_addr]));
        check("halt_in_restore", 64'(bus.halt_o), 64'(1));
        writes++;
        exp_addr++;
        if (abort_at > 0 && writes == abort_at) begin
          rst_ni = 1'b0;
          #1;
          check_all_zero("abort");
          model_cnt = 0;
          @(negedge clk_i);
          check_all_zero("abort_hold");
          bus.error_i       = 1'b0;
          bus.valid_instr_i = 1'b0;
          bus.halt_ack_i    = 1'b0;
          rst_ni            = 1'b1;
          for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            check("abort_no_resume", 64'(bus.resume_o), 64'(0));
            check("abort_no_halt",   64'(bus.halt_o),   64'(0));
            check("abort_idle_busy", 64'(bus.busy_o),   64'(0));
          end
          $display("[TB] recovery %0d pc=0x%08h aborted by reset at write %0d", rec_idx, pc, writes);
          rec_idx++;
          return;
        end
      end else if (bus.resume_o) begin
        done = 1'b1;
      end else begin
        check("restore_gap", 64'(bus.rf_we_o), 64'(1));
      end
    end

    if (!done) begin
      check("resume_timeout", 64'(0), 64'(1));
    end else begin
      model_cnt = (model_cnt < CNT_SAT) ? model_cnt + 1 : CNT_SAT;
      check("resume_pc",   64'(bus.resume_pc_o), 64'(pc));
      check("write_count", 64'(writes), 64'(NR - 1));
      check("latency",     64'(k), 64'(1 + (ack_dly + 1) + (NR - 1)));
      check("resume_halt", 64'(bus.halt_o), 64'(0));
      check("resume_we",   64'(bus.rf_we_o), 64'(0));
      check("resume_busy", 64'(bus.busy_o), 64'(1));
      check("cnt",         64'(bus.recovery_cnt_o), 64'(model_cnt));
    end
    bus.halt_ack_i = 1'($urandom);

    @(negedge clk_i);
    check("post_resume_pulse", 64'(bus.resume_o), 64'(0));
    check("post_busy",         64'(bus.busy_o), 64'(0));
    check("post_halt",         64'(bus.halt_o), 64'(0));
    check("post_cnt",          64'(bus.recovery_cnt_o), 64'(model_cnt));
    check("post_pc_hold",      64'(bus.resume_pc_o), 64'(pc));
    bus.error_i       = 1'b0;
    bus.valid_instr_i = 1'b0;
    bus.halt_ack_i    = 1'b0;
    $display("[TB] recovery %0d pc=0x%08h ack_dly=%0d noise=%0d writes=%0d cnt=%0d",
             rec_idx, pc, ack_dly, noise, writes, bus.recovery_cnt_o);
    rec_idx++;
  endtask

  initial begin
    rst_ni            = 1'b0;
    bus.error_i       = 1'b0;
    bus.valid_instr_i = 1'b0;
    bus.fault_pc_i    = '0;
    bus.halt_ack_i    = 1'b0;
    for (int i = 0; i < NR; i++) shadow_mem[i] = '0;

    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    rst_ni = 1'b1;

    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      check("idle_halt", 64'(bus.halt_o), 64'(0));
      check("idle_busy", 64'(bus.busy_o), 64'(0));
      check("idle_we",   64'(bus.rf_we_o), 64'(0));
      check("idle_cnt",  64'(bus.recovery_cnt_o), 64'(0));
    end
    $display("[TB] idle 20 cycles after reset");

    bus.error_i       = 1'b1;
    bus.valid_instr_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.fault_pc_i = $urandom;
      @(negedge clk_i);
      check("unqual_halt", 64'(bus.halt_o), 64'(0));
      check("unqual_busy", 64'(bus.busy_o), 64'(0));
    end
    bus.error_i = 1'b0;
    $display("[TB] unqualified error for 10 cycles ignored");

    do_recovery(32'h0000_0100, 3, 1'b1, 1'b0, 0);
    do_recovery($urandom, $urandom_range(0, 4), 1'b0, 1'b1, 0);
    do_recovery($urandom, 2, 1'b0, 1'b0, 10);
    do_recovery($urandom, $urandom_range(0, 4), 1'b0, 1'b0, 0);

    while (model_cnt < CNT_SAT) begin
      do_recovery($urandom, $urandom_range(0, 3), 1'b0, 1'($urandom), 0);
    end
    for (int r = 0; r < 3; r++) begin
      do_recovery($urandom, $urandom_range(0, 3), 1'b0, 1'b0, 0);
    end
    check("cnt_saturated", 64'(bus.recovery_cnt_o), 64'(CNT_SAT));

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/ft_recovery_ctrl.md
Name: ft_recovery_ctrl

Overview:
- Recovery controller for the dual-core lockstep pair; acts on the mismatch flag produced by the writeback comparator.
- On a qualified error it halts both cores and rewrites every architectural register in both cores from the protected shadow register file. The shadow file holds only comparator-approved writebacks.
- It then restarts both cores at the PC of the faulting instruction.
- Sits between the comparator and the two cores' register-file write ports and debug/halt controls.

Parameters:
- ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 32, register data and PC width.
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_WIDTH.
- CNT_WIDTH, 8, width of the saturating recovery-event counter.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- error_i  in  1  mismatch flag from the comparator.
- valid_instr_i  in  1  qualifies error_i; error_i is ignored when low.
- fault_pc_i  in  DATA_WIDTH  PC of the instruction currently at writeback.
- halt_o  out  1  halt request to both cores.
- halt_ack_i  in  1  high when both cores are halted.
- sh_raddr_o  out  ADDR_WIDTH  shadow register file read address; combinational read.
- sh_rdata_i  in  DATA_WIDTH  shadow register file read data, valid in the same cycle.
- rf_we_o  out  1  write enable broadcast to both cores' register files.
- rf_waddr_o  out  ADDR_WIDTH  write address broadcast to both cores.
- rf_wdata_o  out  DATA_WIDTH  write data broadcast to both cores.
- resume_o  out  1  single-cycle restart pulse to both cores.
- resume_pc_o  out  DATA_WIDTH  restart PC; valid while resume_o is high.
- busy_o  out  1  high in every state except IDLE.
- recovery_cnt_o  out  CNT_WIDTH  count of completed recoveries, saturating.

Behaviour:
- Reset values (async on rst_ni low): state IDLE. All outputs 0: halt_o, rf_we_o, rf_waddr_o, rf_wdata_o, sh_raddr_o, resume_o, resume_pc_o, busy_o, recovery_cnt_o. Internal address counter 0, latched PC 0.
- Reset mid-recovery aborts immediately with no completion. After release the FSM is in IDLE and the cores are no longer halted by this block.
- Qualified error: error_i and valid_instr_i both high at a rising edge, sampled only in IDLE.
- Qualified error at edge N:
  - latch fault_pc_i;
  - go to HALT;
  - halt_o and busy_o high from cycle N+1.
- HALT:
  - Hold halt_o high; wait for halt_ack_i.
  - On halt_ack_i high at an edge: go to RESTORE, load address counter with 1.
  - x0 is never written.
- RESTORE:
  - halt_o stays high; rf_we_o is high every cycle.
  - sh_raddr_o = rf_waddr_o = counter; rf_wdata_o = sh_rdata_i (combinational pass-through).
  - Counter increments each cycle.
  - When counter equals NUM_REGS-1, that write completes and the FSM goes to RESUME.
  - Duration is exactly NUM_REGS-1 cycles (31 at default). No wrap-around.
- RESUME:
  - Exactly one cycle: resume_o high, resume_pc_o = latched PC, halt_o low, rf_we_o low.
  - recovery_cnt_o increments, holding at all-ones once saturated.
  - Next state IDLE.
- In IDLE:
  - sh_raddr_o and rf_waddr_o are 0; rf_we_o is 0.
  - resume_pc_o holds its last value; resume_o is 0.
- Errors outside IDLE are ignored and not queued, since the cores are halted and the comparator output is stale. An error in the same cycle as RESUME is ignored.
- halt_ack_i is don't-care outside HALT. If halt_ack_i drops during RESTORE, the FSM continues; that is a core protocol violation and is not handled.
- Total latency, error edge to resume_o pulse: 1 + H + (NUM_REGS-1) cycles, where H ≥ 1 is the number of HALT cycles until ack.

Test Plan:
- Reset then idle, 20 cycles with error_i=0 -> all outputs 0, busy_o=0, recovery_cnt_o=0.
- error_i=1 with valid_instr_i=0 -> no state change, halt_o stays 0.
- error_i=1, valid_instr_i=1, fault_pc_i=0x0000_0100; halt_ack_i rises 3 cycles after halt_o; shadow file holds reg[k]=0xA5A5_0000+k:
  - halt_o high the next cycle;
  - 31 consecutive writes to addresses 1..31 with data 0xA5A5_0001..0xA5A5_001F, address 0 never written;
  - then one resume_o pulse with resume_pc_o=0x0000_0100;
  - recovery_cnt_o=1; busy_o low the following cycle.
- Second error pulsed during RESTORE -> ignored: exactly 31 writes, one resume_o, recovery_cnt_o increments by 1 only.
- rst_ni asserted at the 10th RESTORE write -> outputs immediately 0, no resume_o. After release, a new error starts a full recovery from address 1.
- Force 256 recoveries with CNT_WIDTH=8 -> recovery_cnt_o saturates at 0xFF and stays there.
